pipeline_controller: RTL and testbench

- Central hazard and sequencing controller for the 5-stage RV32i pipeline (F/D/E/M/W).
- Produces per-stage stall/flush enables from decode- and execute-stage control signals: load-use stalls, branch/jump redirects, multi-cycle data-memory waits.
- Handles illegal instructions flagged by control_unit: drains older instructions, then halts the core.
- Sits beside control_unit in decode; its outputs drive the pipeline-register enables and clears.

---
 rtl/pipeline_controller.sv | 202 ++++++++++++++++++++
 tb/tb_pipeline_controller.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_controller.sv
// pipeline_controller
//   Hazard and sequencing controller for the 5-stage RV32i pipeline.
//   Generates per-stage stall/flush enables for load-use hazards,
//   branch/jump redirects and multi-cycle data-memory waits. Handles
//   illegal decode instructions by draining older work, then halting.
//
// Parameters
//   DRAIN_CYCLES : non-stalled cycles spent draining before HALT (>= 1)
//   MEM_TIMEOUT  : stalled memory cycles before Mem_Timeout sets (0 = off)
//
// Ports
//   CLK, RST                  clock (rising edge), synchronous active-high reset
//   D_RS1_Addr, D_RS2_Addr    decode-stage source register indices
//   D_Illegal                 decode instruction flagged as illegal
//   E_RD_Addr, E_Load,
//   E_REG_W_En                execute-stage destination / load / write enable
//   E_Redirect                execute stage resolved a taken branch or jump
//   M_MEM_Req, M_MEM_Ready    memory-stage request and completion
//   F_Stall, D_Stall          hold PC + F/D, hold D/E input
//   D_Flush, E_Flush          clear F/D, clear D/E
//   M_Stall                   hold E/M and M/W during a memory wait
//   Halted                    core stopped
//   Mem_Timeout               sticky memory-wait timeout flag
//
// Optional feature (macro PIPELINE_PERF_COUNTERS_EN)
//   Adds Stall_Count (F_Stall cycles in RUN/MEM_WAIT) and Flush_Count
//   (redirect flush cycles), both 32-bit, wrapping, cleared by RST.

module pipeline_controller #(
  parameter int DRAIN_CYCLES = 3,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] D_RS1_Addr,
  input  logic [4:0] D_RS2_Addr,
  input  logic       D_Illegal,
  input  logic [4:0] E_RD_Addr,
  input  logic       E_Load,
  input  logic       E_REG_W_En,
  input  logic       E_Redirect,
  input  logic       M_MEM_Req,
  input  logic       M_MEM_Ready,
  output logic       F_Stall,
  output logic       D_Stall,
  output logic       D_Flush,
  output logic       E_Flush,
  output logic       M_Stall,
  output logic       Halted,
  output logic       Mem_Timeout
`ifdef PIPELINE_PERF_COUNTERS_EN
  ,
  output logic [31:0] Stall_Count,
  output logic [31:0] Flush_Count
`endif
);

  localparam int WW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);
  localparam logic [WW-1:0] WAIT_LIMIT = WW'(MEM_TIMEOUT);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALT} state_t;

  state_t          state_reg, state_next;
  logic [DW-1:0]   drain_cnt_reg, drain_cnt_next;
  logic [WW-1:0]   wait_cnt_reg, wait_cnt_next;
  logic            timeout_reg, timeout_next;

  logic            mem_busy;
  logic            load_use;
  logic            redirect_flush;
  logic [WW-1:0]   wait_inc;

  assign mem_busy = M_MEM_Req & ~M_MEM_Ready;
  // x0 is hardwired to zero, so a load targeting it can never create a hazard.
  assign load_use = E_Load & E_REG_W_En & (E_RD_Addr != 5'd0) &
                    ((E_RD_Addr == D_RS1_Addr) | (E_RD_Addr == D_RS2_Addr));
  // Wait counter saturates at the timeout value.
  assign wait_inc = (wait_cnt_reg == WAIT_LIMIT) ? wait_cnt_reg : wait_cnt_reg + 1'b1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= RUN;
      drain_cnt_reg <= '0;
      wait_cnt_reg  <= '0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      drain_cnt_reg <= drain_cnt_next;
      wait_cnt_reg  <= wait_cnt_next;
      timeout_reg   <= timeout_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    drain_cnt_next = drain_cnt_reg;
    wait_cnt_next  = wait_cnt_reg;
    F_Stall        = 1'b0;
    D_Stall        = 1'b0;
    D_Flush        = 1'b0;
    E_Flush        = 1'b0;
    M_Stall        = 1'b0;
    Halted         = 1'b0;
    redirect_flush = 1'b0;

    case (state_reg)
      RUN: begin
        wait_cnt_next = '0;
        if (mem_busy) begin
          // The first stalled cycle already counts toward the timeout.
          F_Stall       = 1'b1;
          D_Stall       = 1'b1;
          M_Stall       = 1'b1;
          wait_cnt_next = wait_inc;
          state_next    = MEM_WAIT;
        end else if (E_Redirect) begin
          // Flushing D also discards any load-use or illegal decode.
          D_Flush        = 1'b1;
          E_Flush        = 1'b1;
          redirect_flush = 1'b1;
        end else if (load_use) begin
          F_Stall = 1'b1;
          D_Stall = 1'b1;
          E_Flush = 1'b1;
        end else if (D_Illegal) begin
          // Bubble replaces the illegal instruction; older ones drain out.
          F_Stall        = 1'b1;
          E_Flush        = 1'b1;
          drain_cnt_next = DRAIN_INIT;
          state_next     = DRAIN;
        end
      end

      MEM_WAIT: begin
        F_Stall = 1'b1;
        D_Stall = 1'b1;
        M_Stall = 1'b1;
        if (M_MEM_Ready) begin
          wait_cnt_next = '0;
          state_next    = RUN;
        end else begin
          wait_cnt_next = wait_inc;
        end
      end

      DRAIN: begin
        // Redirects are ignored here: they come from younger instructions.
        F_Stall = 1'b1;
        E_Flush = 1'b1;
        if (mem_busy) begin
          M_Stall       = 1'b1;
          wait_cnt_next = wait_inc;
        end else begin
          wait_cnt_next = '0;
          if (drain_cnt_reg == '0) begin
            state_next = HALT;
          end else begin
            drain_cnt_next = drain_cnt_reg - 1'b1;
          end
        end
      end

      HALT: begin
        F_Stall = 1'b1;
        D_Stall = 1'b1;
        E_Flush = 1'b1;
        Halted  = 1'b1;
      end

      default: state_next = RUN;
    endcase

    timeout_next = timeout_reg | ((MEM_TIMEOUT != 0) && (wait_cnt_next == WAIT_LIMIT));
  end

  assign Mem_Timeout = timeout_reg;

`ifdef PIPELINE_PERF_COUNTERS_EN
  logic [31:0] stall_count_reg;
  logic [31:0] flush_count_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_count_reg <= '0;
      flush_count_reg <= '0;
    end else begin
      if (F_Stall && (state_reg == RUN || state_reg == MEM_WAIT)) begin
        stall_count_reg <= stall_count_reg + 32'd1;
      end
      if (redirect_flush) begin
        flush_count_reg <= flush_count_reg + 32'd1;
      end
    end
  end

  assign Stall_Count = stall_count_reg;
  assign Flush_Count = flush_count_reg;
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// tb_pipeline_controller
//   Self-checking bench for pipeline_controller: a table of single-cycle
//   RUN-state vectors, hand-written multi-cycle sequences (memory wait,
//   timeout, illegal drain/halt, reset mid-drain) and a randomized phase
//   checked against a behavioural model.
//   Output vector order: {F_Stall, D_Stall, D_Flush, E_Flush, M_Stall, Halted, Mem_Timeout}

module tb_pipeline_controller;

  localparam int DRAIN_N = 3;
  localparam int TO_N    = 15;

  logic       CLK = 1'b0;
  logic       RST;
  logic [4:0] D_RS1_Addr, D_RS2_Addr, E_RD_Addr;
  logic       D_Illegal, E_Load, E_REG_W_En, E_Redirect, M_MEM_Req, M_MEM_Ready;
  logic       F_Stall, D_Stall, D_Flush, E_Flush, M_Stall, Halted, Mem_Timeout;
`ifdef PIPELINE_PERF_COUNTERS_EN
  logic [31:0] Stall_Count, Flush_Count;
`endif

  pipeline_controller #(.DRAIN_CYCLES(DRAIN_N), .MEM_TIMEOUT(TO_N)) dut (
    .CLK(CLK), .RST(RST),
    .D_RS1_Addr(D_RS1_Addr), .D_RS2_Addr(D_RS2_Addr), .D_Illegal(D_Illegal),
    .E_RD_Addr(E_RD_Addr), .E_Load(E_Load), .E_REG_W_En(E_REG_W_En),
    .E_Redirect(E_Redirect), .M_MEM_Req(M_MEM_Req), .M_MEM_Ready(M_MEM_Ready),
    .F_Stall(F_Stall), .D_Stall(D_Stall), .D_Flush(D_Flush), .E_Flush(E_Flush),
    .M_Stall(M_Stall), .Halted(Halted), .Mem_Timeout(Mem_Timeout)
`ifdef PIPELINE_PERF_COUNTERS_EN
    , .Stall_Count(Stall_Count), .Flush_Count(Flush_Count)
`endif
  );

  always #5 CLK = ~CLK;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       ill, ld, we, redir, req, rdy;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[12];

  // Behavioural model: how far along each multi-cycle activity is.
  bit m_halt, m_wait, m_to;
  int m_drain_left;   // -1 = not draining
  int m_stalled;      // consecutive memory-stalled cycles seen

  function automatic logic [6:0] outs();
    return {F_Stall, D_Stall, D_Flush, E_Flush, M_Stall, Halted, Mem_Timeout};
  endfunction

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b (F D DF EF M H TO)", name, got, exp);
    end else begin
      $display("ok   %s: %b", name, got);
    end
  endtask

  task automatic idle();
    D_RS1_Addr = 0; D_RS2_Addr = 0; E_RD_Addr = 0;
    D_Illegal = 0; E_Load = 0; E_REG_W_En = 0; E_Redirect = 0;
    M_MEM_Req = 0; M_MEM_Ready = 0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  function automatic logic [6:0] model_out();
    bit busy, lu;
    logic [6:0] e;
    busy = M_MEM_Req && !M_MEM_Ready;
    lu = E_Load && E_REG_W_En && E_RD_Addr != 0 &&
         (E_RD_Addr == D_RS1_Addr || E_RD_Addr == D_RS2_Addr);
    e = 7'b0;
    if (m_halt)                e = 7'b1101010;
    else if (m_drain_left >= 0) e = {1'b1, 1'b0, 1'b0, 1'b1, busy, 1'b0, 1'b0};
    else if (m_wait)           e = 7'b1100100;
    else if (busy)             e = 7'b1100100;
    else if (E_Redirect)       e = 7'b0011000;
    else if (lu)               e = 7'b1101000;
    else if (D_Illegal)        e = 7'b1001000;
    e[0] = m_to;
    return e;
  endfunction

  task automatic model_step();
    bit busy, lu;
    busy = M_MEM_Req && !M_MEM_Ready;
    lu = E_Load && E_REG_W_En && E_RD_Addr != 0 &&
         (E_RD_Addr == D_RS1_Addr || E_RD_Addr == D_RS2_Addr);
    if (RST) begin
      m_halt = 0; m_wait = 0; m_to = 0; m_drain_left = -1; m_stalled = 0;
      return;
    end
    if (m_halt) begin
      // nothing changes until reset
    end else if (m_drain_left >= 0) begin
      if (busy) m_stalled++;
      else begin
        m_stalled = 0;
        if (m_drain_left == 0) begin m_halt = 1; m_drain_left = -1; end
        else m_drain_left--;
      end
    end else if (m_wait) begin
      if (M_MEM_Ready) begin m_wait = 0; m_stalled = 0; end
      else m_stalled++;
    end else begin
      m_stalled = 0;
      if (busy) begin m_wait = 1; m_stalled = 1; end
      else if (!E_Redirect && !lu && D_Illegal) m_drain_left = DRAIN_N - 1;
    end
    if (m_stalled >= TO_N) m_stalled = TO_N;
    if (m_stalled >= TO_N) m_to = 1;
  endtask

  initial begin
    //        rs1 rs2 rd ill ld we rdir req rdy  exp
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000}; // idle
    vecs[1]  = '{1, 5, 5, 0, 1, 1, 0, 0, 0, 7'b1101000}; // load-use rs2
    vecs[2]  = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 7'b0000000}; // rd=x0 no hazard
    vecs[3]  = '{7, 2, 7, 0, 1, 1, 0, 0, 0, 7'b1101000}; // load-use rs1
    vecs[4]  = '{7, 2, 7, 0, 1, 0, 0, 0, 0, 7'b0000000}; // load without write
    vecs[5]  = '{7, 2, 7, 0, 0, 1, 0, 0, 0, 7'b0000000}; // ALU op, no hazard
    vecs[6]  = '{1, 5, 5, 0, 1, 1, 1, 0, 0, 7'b0011000}; // redirect beats hazard
    vecs[7]  = '{1, 5, 5, 0, 1, 1, 1, 1, 0, 7'b1100100}; // mem wait beats all
    vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 7'b0000000}; // mem completes at once
    vecs[9]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 7'b1001000}; // illegal
    vecs[10] = '{3, 4, 4, 1, 1, 1, 0, 0, 0, 7'b1101000}; // hazard before illegal
    vecs[11] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 7'b0011000}; // redirect over illegal

    idle();
    RST = 1'b0;
    tick();
    do_reset();
    check("reset_state", outs(), 7'b0);

    foreach (vecs[i]) begin
      do_reset();
      D_RS1_Addr = vecs[i].rs1; D_RS2_Addr = vecs[i].rs2; E_RD_Addr = vecs[i].rd;
      D_Illegal = vecs[i].ill; E_Load = vecs[i].ld; E_REG_W_En = vecs[i].we;
      E_Redirect = vecs[i].redir; M_MEM_Req = vecs[i].req; M_MEM_Ready = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
      idle();
    end

    // Memory wait: ready low 4 cycles, then high -> 5 stalled cycles.
    do_reset();
    M_MEM_Req = 1;
    for (int c = 0; c < 6; c++) begin
      M_MEM_Ready = (c >= 4);
      if (c == 5) M_MEM_Req = 0;
      #1;
      check($sformatf("memwait_c%0d", c), outs(), (c < 5) ? 7'b1100100 : 7'b0);
      tick();
    end

    // Timeout: ready low 20 cycles; flag appears from cycle 15 and sticks.
    do_reset();
    M_MEM_Req = 1; M_MEM_Ready = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      check($sformatf("timeout_c%0d", c), outs(), {6'b110010, 1'(c >= TO_N)});
      tick();
    end
    M_MEM_Ready = 1;
    tick();
    idle();
    #1;
    check("timeout_sticky", outs(), 7'b0000001);
    tick();
    do_reset();
    #1;
    check("timeout_cleared", outs(), 7'b0);

    // Illegal instruction (e.g. MUL 0x028701B3): 3 drain cycles then halt.
    do_reset();
    D_Illegal = 1;
    #1;
    check("illegal_detect", outs(), 7'b1001000);
    tick();
    idle();
    for (int c = 0; c < DRAIN_N; c++) begin
      E_Redirect = (c == 1);
      #1;
      check($sformatf("drain_c%0d", c), outs(), 7'b1001000);
      tick();
    end
    idle();
    for (int c = 0; c < 4; c++) begin
      E_Redirect = (c == 2);
      #1;
      check($sformatf("halt_c%0d", c), outs(), 7'b1101010);
      tick();
    end
    idle();
    do_reset();
    #1;
    check("halt_reset", outs(), 7'b0);

    // Reset in the second drain cycle.
    do_reset();
    D_Illegal = 1;
    tick();
    idle();
    tick();
    RST = 1;
    tick();
    RST = 0;
    #1;
    check("drain_reset_outs", outs(), 7'b0);
    E_Load = 1; E_REG_W_En = 1; E_RD_Addr = 9; D_RS1_Addr = 9;
    #1;
    check("drain_reset_resume", outs(), 7'b1101000);
    idle();

    // Randomized phase against the behavioural model.
    do_reset();
    m_halt = 0; m_wait = 0; m_to = 0; m_drain_left = -1; m_stalled = 0;
    for (int c = 0; c < 3000; c++) begin
      RST         = ($urandom_range(79) == 0);
      D_RS1_Addr  = 5'($urandom_range(3));
      D_RS2_Addr  = 5'($urandom_range(3));
      E_RD_Addr   = 5'($urandom_range(3));
      D_Illegal   = ($urandom_range(39) == 0);
      E_Load      = ($urandom_range(1) == 0);
      E_REG_W_En  = ($urandom_range(3) != 0);
      E_Redirect  = ($urandom_range(5) == 0);
      M_MEM_Req   = ($urandom_range(3) == 0) || (c % 400 < 25);
      M_MEM_Ready = (c % 400 < 25) ? 1'b0 : ($urandom_range(2) == 0);
      #1;
      check($sformatf("rand_c%0d", c), outs(), model_out());
      @(posedge CLK);
      model_step();
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
